// File: rtl/uart_tx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_ctrl
//
// Parametrised UART transmit frame controller. One block handles frame
// sequencing, the payload/option latch, the per-bit oversampling counter, the
// data bit index, parity generation and the serial output select. Frames are
// start(0), DATA_WIDTH data bits LSB first, optional parity, then one or two
// stop bits(1). Back-to-back frames are accepted on the last cycle of the
// final stop bit, so there is no idle gap between them.
//
// Parameters:
//   DATA_WIDTH    payload bits per frame (5..9)
//   CLKS_PER_BIT  CLK cycles per serial bit (>=1, 1 = CLK is the baud clock)
//
// Ports:
//   CLK         clock, all state updates on the rising edge
//   RST         asynchronous active-high reset
//   P_DATA      parallel payload, sampled only on acceptance
//   Data_Valid  request to send P_DATA
//   PAR_EN      1 = insert parity bit (sampled on acceptance)
//   PAR_TYP     0 = even, 1 = odd parity (sampled on acceptance)
//   STOP2       1 = two stop bits (sampled on acceptance)
//   TX_OUT      registered serial line, idles high
//   busy        registered, high while a frame is on the line
//   frame_done  registered pulse on the last CLK cycle of the final stop bit
// ---------------------------------------------------------------------------
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         bitCnt_q, bitCnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  stopIdx_q, stopIdx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  parEn_q, parEn_d;
  logic                  parBit_q, parBit_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  bitEnd;
  logic                  accept;

  assign TX_OUT     = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      idx_q     <= '0;
      stopIdx_q <= 1'b0;
      data_q    <= '0;
      parEn_q   <= 1'b0;
      parBit_q  <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      idx_q     <= idx_d;
      stopIdx_q <= stopIdx_d;
      data_q    <= data_d;
      parEn_q   <= parEn_d;
      parBit_q  <= parBit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    idx_d     = idx_q;
    stopIdx_d = stopIdx_q;
    data_d    = data_q;
    parEn_d   = parEn_q;
    parBit_d  = parBit_q;
    stop2_d   = stop2_q;
    accept    = 1'b0;
    bitEnd    = (bitCnt_q == BIT_LAST);

    // The oversampling counter free-runs within every bit of a frame and
    // restarts at each bit boundary.
    if (state_q != IDLE) begin
      bitCnt_d = bitEnd ? '0 : bitCnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        bitCnt_d  = '0;
        idx_d     = '0;
        stopIdx_d = 1'b0;
        if (Data_Valid) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (idx_q == IDX_LAST) begin
            state_d   = parEn_q ? PAR : STOP;
            stopIdx_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (bitEnd) begin
          state_d   = STOP;
          stopIdx_d = 1'b0;
        end
      end
      STOP: begin
        if (bitEnd) begin
          // stopIdx_q == stop2_q marks the final stop bit: bit 0 with one
          // stop bit, bit 1 with two.
          if (stopIdx_q == stop2_q) begin
            stopIdx_d = 1'b0;
            idx_d     = '0;
            if (Data_Valid) begin
              accept  = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stopIdx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bitCnt_d  = '0;
        idx_d     = '0;
        stopIdx_d = 1'b0;
      end
    endcase

    if (accept) begin
      data_d   = P_DATA;
      parEn_d  = PAR_EN;
      stop2_d  = STOP2;
      parBit_d = (^P_DATA) ^ PAR_TYP;
    end
  end

  // Outputs are registered from the next-state values so that they line up
  // with the state register, with no combinational path from the inputs.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[idx_d];
      PAR:     tx_d = parBit_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (bitCnt_d == BIT_LAST) && (stopIdx_d == stop2_d);
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame_ctrl
//
// Directed bench for uart_tx_frame_ctrl. Two instances share all inputs:
// dut1 (CLKS_PER_BIT=1) and dut4 (CLKS_PER_BIT=4), both DATA_WIDTH=8.
// Inputs change and outputs are sampled on the falling edge of CLK.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic       tx1, busy1, done1;
  logic       tx4, busy4, done4;

  int testsRun  = 0;
  int failCount = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(tx1), .busy(busy1), .frame_done(done1)
  );

  uart_tx_frame_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(tx4), .busy(busy4), .frame_done(done4)
  );

  // Put both instances back in IDLE; returns on a falling edge.
  task automatic doReset;
    Data_Valid = 1'b0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    #1;
    testsRun++;
    if (tx1 !== 1'b1) begin failCount++; $display("[TB] FAIL reset_tx1: got %b want 1", tx1); end
    testsRun++;
    if (busy1 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy1: got %b want 0", busy1); end
    testsRun++;
    if (done1 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done1: got %b want 0", done1); end
    testsRun++;
    if (tx4 !== 1'b1) begin failCount++; $display("[TB] FAIL reset_tx4: got %b want 1", tx4); end
    testsRun++;
    if (busy4 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy4: got %b want 0", busy4); end
    doReset;
    testsRun++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_idle: got tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
    end
  endtask

  task automatic test_basic;
    logic [0:9] expBits;
    expBits = 10'b0101001011;
    doReset;
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      testsRun++;
      if (tx1 !== expBits[i]) begin failCount++; $display("[TB] FAIL basic_tx cycle %0d: got %b want %b", i + 1, tx1, expBits[i]); end
      testsRun++;
      if (busy1 !== 1'b1) begin failCount++; $display("[TB] FAIL basic_busy cycle %0d: got %b want 1", i + 1, busy1); end
      testsRun++;
      if (done1 !== (i == 9)) begin failCount++; $display("[TB] FAIL basic_done cycle %0d: got %b want %b", i + 1, done1, (i == 9)); end
      @(negedge CLK);
    end
    testsRun++;
    if (busy1 !== 1'b0 || tx1 !== 1'b1 || done1 !== 1'b0) begin
      failCount++; $display("[TB] FAIL basic_after: got tx=%b busy=%b done=%b want 1 0 0", tx1, busy1, done1);
    end
  endtask

  task automatic test_parity;
    logic [7:0]  dat [3];
    logic        typ [3];
    logic [0:10] expBits [3];
    dat = '{8'hA5, 8'hA5, 8'h01};
    typ = '{1'b0, 1'b1, 1'b0};
    expBits = '{11'b01010010101, 11'b01010010111, 11'b01000000011};
    doReset;
    for (int f = 0; f < 3; f++) begin
      P_DATA = dat[f]; PAR_EN = 1'b1; PAR_TYP = typ[f]; STOP2 = 1'b0; Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      for (int i = 0; i < 11; i++) begin
        testsRun++;
        if (tx1 !== expBits[f][i]) begin
          failCount++; $display("[TB] FAIL parity_tx frame %0d cycle %0d: got %b want %b", f, i + 1, tx1, expBits[f][i]);
        end
        testsRun++;
        if (busy1 !== 1'b1 || done1 !== (i == 10)) begin
          failCount++; $display("[TB] FAIL parity_ctrl frame %0d cycle %0d: got busy=%b done=%b want 1 %b", f, i + 1, busy1, done1, (i == 10));
        end
        @(negedge CLK);
      end
      testsRun++;
      if (busy1 !== 1'b0) begin failCount++; $display("[TB] FAIL parity_after frame %0d: got busy=%b want 0", f, busy1); end
    end
  endtask

  task automatic test_oversample;
    logic [0:11] expBits;
    expBits = 12'b011111111011;
    doReset;
    P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b1; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; i < 48; i++) begin
      testsRun++;
      if (tx4 !== expBits[i / 4]) begin failCount++; $display("[TB] FAIL os_tx cycle %0d: got %b want %b", i + 1, tx4, expBits[i / 4]); end
      testsRun++;
      if (busy4 !== 1'b1) begin failCount++; $display("[TB] FAIL os_busy cycle %0d: got %b want 1", i + 1, busy4); end
      testsRun++;
      if (done4 !== (i == 47)) begin failCount++; $display("[TB] FAIL os_done cycle %0d: got %b want %b", i + 1, done4, (i == 47)); end
      if (i == 10) begin
        P_DATA = 8'h00; PAR_TYP = 1'b1; PAR_EN = 1'b0; STOP2 = 1'b0;
      end
      @(negedge CLK);
    end
    testsRun++;
    if (busy4 !== 1'b0 || tx4 !== 1'b1) begin
      failCount++; $display("[TB] FAIL os_after: got tx=%b busy=%b want 1 0", tx4, busy4);
    end
  endtask

  task automatic test_back_to_back;
    logic [0:19] expBits;
    expBits = 20'b0101010101_0111100001;
    doReset;
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    P_DATA = 8'h0F;
    for (int i = 0; i < 20; i++) begin
      testsRun++;
      if (tx1 !== expBits[i]) begin failCount++; $display("[TB] FAIL b2b_tx cycle %0d: got %b want %b", i + 1, tx1, expBits[i]); end
      testsRun++;
      if (busy1 !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_busy cycle %0d: got %b want 1", i + 1, busy1); end
      testsRun++;
      if (done1 !== (i == 9 || i == 19)) begin
        failCount++; $display("[TB] FAIL b2b_done cycle %0d: got %b want %b", i + 1, done1, (i == 9 || i == 19));
      end
      if (i == 10) Data_Valid = 1'b0;
      @(negedge CLK);
    end
    testsRun++;
    if (busy1 !== 1'b0 || tx1 !== 1'b1) begin
      failCount++; $display("[TB] FAIL b2b_after: got tx=%b busy=%b want 1 0", tx1, busy1);
    end
  endtask

  task automatic test_ignore_mid;
    logic [0:9] expBits;
    expBits = 10'b0101001011;
    doReset;
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      testsRun++;
      if (tx1 !== expBits[i] || busy1 !== 1'b1) begin
        failCount++; $display("[TB] FAIL ignore_tx cycle %0d: got tx=%b busy=%b want %b 1", i + 1, tx1, busy1, expBits[i]);
      end
      if (i == 3) begin Data_Valid = 1'b1; P_DATA = 8'h00; end
      if (i == 4) Data_Valid = 1'b0;
      @(negedge CLK);
    end
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
        failCount++; $display("[TB] FAIL ignore_idle cycle %0d: got tx=%b busy=%b want 1 0", i, tx1, busy1);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid;
    logic [0:9] expBits;
    doReset;
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    testsRun++;
    if (tx1 !== 1'b0) begin failCount++; $display("[TB] FAIL rmid_bit3: got %b want 0", tx1); end
    RST = 1'b1;
    #1;
    testsRun++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      failCount++; $display("[TB] FAIL rmid_async1: got tx=%b busy=%b done=%b want 1 0 0", tx1, busy1, done1);
    end
    testsRun++;
    if (tx4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      failCount++; $display("[TB] FAIL rmid_async4: got tx=%b busy=%b done=%b want 1 0 0", tx4, busy4, done4);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    testsRun++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
      failCount++; $display("[TB] FAIL rmid_no_resume: got tx=%b busy=%b want 1 0", tx1, busy1);
    end
    expBits = 10'b0100000001;
    P_DATA = 8'h01; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      testsRun++;
      if (tx1 !== expBits[i] || busy1 !== 1'b1 || done1 !== (i == 9)) begin
        failCount++; $display("[TB] FAIL rmid_frame cycle %0d: got tx=%b busy=%b done=%b want %b 1 %b", i + 1, tx1, busy1, done1, expBits[i], (i == 9));
      end
      @(negedge CLK);
    end
    testsRun++;
    if (busy1 !== 1'b0) begin failCount++; $display("[TB] FAIL rmid_after: got busy=%b want 0", busy1); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b1;
    P_DATA = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    STOP2 = 1'b0;
    @(negedge CLK);
    test_reset;
    test_basic;
    test_parity;
    test_oversample;
    test_back_to_back;
    test_ignore_mid;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
